// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage of the single-cycle RISC-V core. It owns the program
// counter and fetches one instruction word at a time from instruction memory
// over a req/rvalid handshake. Each word is presented to decode with a
// valid/ready handshake. The branch decision and offset that come back on that
// handshake select the next PC. A misaligned next PC parks the unit in a
// terminal FAULT state until reset.
//
// Ports:
//   clk            core clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   mem_req_o      instruction memory request (exactly one outstanding)
//   mem_addr_o     fetch address, valid while mem_req_o=1
//   mem_rvalid_i   memory response valid
//   mem_rdata_i    instruction word, valid with mem_rvalid_i
//   instr_o        instruction presented to decode
//   pc_o           address of instr_o
//   instr_valid_o  instr_o/pc_o valid
//   decode_ready_i decode accepts instr_o this cycle
//   branch_i       PCsrc for the presented instruction, used only on handshake
//   imm_i          sign-extended branch offset, used only on handshake
//   fault_o        sticky misaligned-target flag

module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  instr_valid_o,
    input  logic                  decode_ready_i,
    input  logic                  branch_i,
    input  logic [DATA_WIDTH-1:0] imm_i,
    output logic                  fault_o
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD,
        FAULT
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] imm_addr;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic                  handshake;
    logic                  capture;
    logic                  misaligned;

    // Next-PC arithmetic wraps modulo 2^ADDR_WIDTH on purpose. The offset
    // is used at address width.
    always_comb begin
        imm_addr   = ADDR_WIDTH'(imm_i);
        next_pc    = branch_i ? (pc_o + imm_addr) : (pc_o + ADDR_WIDTH'(4));
        misaligned = |next_pc[1:0];
        handshake  = (state == HOLD) && instr_valid_o && decode_ready_i;
        // A response only counts once the request is actually on the bus.
        // This keeps the bubble cycle in FETCH and every other state deaf
        // to rvalid.
        capture    = (state == FETCH) && mem_req_o && mem_rvalid_i;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = FETCH;
            FETCH:   if (capture) state_next = HOLD;
            HOLD:    if (handshake) state_next = misaligned ? FAULT : FETCH;
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    // Datapath. On entry to FETCH, the request is raised one edge later.
    // That gives the single bubble cycle after each handshake and the
    // two-edge delay after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc      <= RESET_PC;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            instr_o       <= '0;
            pc_o          <= '0;
            instr_valid_o <= 1'b0;
            fault_o       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem_req_o) begin
                        mem_req_o  <= 1'b1;
                        mem_addr_o <= fetch_pc;
                    end else if (capture) begin
                        instr_o       <= mem_rdata_i;
                        pc_o          <= fetch_pc;
                        instr_valid_o <= 1'b1;
                        mem_req_o     <= 1'b0;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        instr_valid_o <= 1'b0;
                        if (misaligned) begin
                            fault_o <= 1'b1;
                        end else begin
                            fetch_pc <= next_pc;
                        end
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed testbench for fetch_unit. The bench plays the instruction memory
// and the decode stage from a single linear initial block. It checks
// addresses, captured words and handshake behaviour against hand-computed
// values.

module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        instr_valid_o;
    logic        decode_ready_i;
    logic        branch_i;
    logic [31:0] imm_i;
    logic        fault_o;

    int nAsserts = 0;
    int nFail    = 0;

    fetch_unit #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .RESET_PC  (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o),
        .instr_valid_o (instr_valid_o),
        .decode_ready_i(decode_ready_i),
        .branch_i      (branch_i),
        .imm_i         (imm_i),
        .fault_o       (fault_o)
    );

    // Free-running clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point. Every check in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        nAsserts++;
        assert (observed === expected)
        else begin
            nFail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Memory side of one fetch. Waits (bounded) for the request, checks the
    // address, and holds rvalid low for 'latency' extra cycles while checking
    // that the request stays stable. It then returns 'data' and checks what
    // decode sees.
    task automatic applyStimulus(input logic [31:0] expAddr, input logic [31:0] data,
                                 input int latency);
        int waitCnt;
        waitCnt = 0;
        while (!mem_req_o && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        checkOutput("req_seen", 32'(mem_req_o), 32'd1);
        checkOutput("fetch_addr", mem_addr_o, expAddr);
        for (int i = 0; i < latency; i++) begin
            @(negedge clk);
            checkOutput("req_held", 32'(mem_req_o), 32'd1);
            checkOutput("addr_held", mem_addr_o, expAddr);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = data;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = $urandom;
        checkOutput("valid_after_rsp", 32'(instr_valid_o), 32'd1);
        checkOutput("instr_captured", instr_o, data);
        checkOutput("pc_captured", pc_o, expAddr);
        checkOutput("req_drop", 32'(mem_req_o), 32'd0);
    endtask

    // One decode handshake with the given branch decision. Branch inputs are
    // scrambled afterwards to show they only matter on the handshake.
    task automatic handshake(input logic br, input logic [31:0] imm);
        checkOutput("valid_before_hs", 32'(instr_valid_o), 32'd1);
        decode_ready_i = 1'b1;
        branch_i       = br;
        imm_i          = imm;
        @(negedge clk);
        decode_ready_i = 1'b0;
        branch_i       = 1'($urandom);
        imm_i          = $urandom;
        checkOutput("valid_after_hs", 32'(instr_valid_o), 32'd0);
        checkOutput("bubble_no_req", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        mem_rvalid_i   = 1'b0;
        mem_rdata_i    = '0;
        decode_ready_i = 1'b0;
        branch_i       = 1'b0;
        imm_i          = '0;

        // Reset values
        repeat (2) @(negedge clk);
        checkOutput("rst_req", 32'(mem_req_o), 32'd0);
        checkOutput("rst_addr", mem_addr_o, 32'h0);
        checkOutput("rst_instr", instr_o, 32'h0);
        checkOutput("rst_pc", pc_o, 32'h0);
        checkOutput("rst_valid", 32'(instr_valid_o), 32'd0);
        checkOutput("rst_fault", 32'(fault_o), 32'd0);

        // Release: the IDLE edge, then the request edge
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_no_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        checkOutput("first_req", 32'(mem_req_o), 32'd1);

        // Sequential fetch 0x0, 0x4, 0x8
        applyStimulus(32'h0000_0000, 32'h0000_0013, 0);
        handshake(1'b0, 32'h0);
        applyStimulus(32'h0000_0004, 32'h0010_0093, 0);
        handshake(1'b0, 32'h0);
        applyStimulus(32'h0000_0008, 32'h0050_0093, 0);

        // Decode stall at 0x8, with junk on branch/imm and spurious rvalid
        for (int i = 0; i < 5; i++) begin
            branch_i     = 1'b1;
            imm_i        = $urandom;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'hDEAD_BEEF;
            @(negedge clk);
            checkOutput("stall_instr", instr_o, 32'h0050_0093);
            checkOutput("stall_pc", pc_o, 32'h0000_0008);
            checkOutput("stall_no_req", 32'(mem_req_o), 32'd0);
            checkOutput("stall_valid", 32'(instr_valid_o), 32'd1);
        end
        mem_rvalid_i = 1'b0;
        handshake(1'b0, 32'h0);
        applyStimulus(32'h0000_000C, 32'h0000_0113, 1);
        handshake(1'b0, 32'h0);

        // Taken branch from 0x10 back by 8 -> 0x08, with latency 3
        applyStimulus(32'h0000_0010, 32'h FE00_0CE3, 0);
        handshake(1'b1, 32'hFFFF_FFF8);
        applyStimulus(32'h0000_0008, 32'h0050_0093, 3);
        handshake(1'b0, 32'h0);
        applyStimulus(32'h0000_000C, 32'h0000_0113, 7);
        handshake(1'b0, 32'h0);

        // Not-taken at 0x10 with a non-zero imm -> 0x14
        applyStimulus(32'h0000_0010, 32'h0000_0663, 0);
        handshake(1'b0, 32'h0000_0100);

        // Branch 0x14 - 0x18 -> 0xFFFF_FFFC
        applyStimulus(32'h0000_0014, 32'h FE00_04E3, 2);
        handshake(1'b1, 32'hFFFF_FFE8);
        applyStimulus(32'hFFFF_FFFC, 32'h0000_0033, 0);
        handshake(1'b0, 32'h0);

        // Wrap to 0x0, then async reset while that fetch is outstanding
        @(negedge clk);
        checkOutput("wrap_req", 32'(mem_req_o), 32'd1);
        checkOutput("wrap_addr", mem_addr_o, 32'h0000_0000);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_req", 32'(mem_req_o), 32'd0);
        checkOutput("async_instr", instr_o, 32'h0);
        checkOutput("async_pc", pc_o, 32'h0);
        checkOutput("async_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_idle_no_req", 32'(mem_req_o), 32'd0);
        @(negedge clk);
        checkOutput("rel_req", 32'(mem_req_o), 32'd1);

        // Misaligned branch target 0x0 + 2 -> FAULT
        applyStimulus(32'h0000_0000, 32'h0020_0063, 4);
        handshake(1'b1, 32'h0000_0002);
        checkOutput("fault_set", 32'(fault_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            mem_rvalid_i   = 1'b1;
            decode_ready_i = 1'b1;
            @(negedge clk);
            checkOutput("fault_no_req", 32'(mem_req_o), 32'd0);
            checkOutput("fault_no_valid", 32'(instr_valid_o), 32'd0);
            checkOutput("fault_sticky", 32'(fault_o), 32'd1);
        end
        mem_rvalid_i   = 1'b0;
        decode_ready_i = 1'b0;

        // Only reset clears the fault
        #2 rst_n = 1'b0;
        #1;
        checkOutput("fault_cleared", 32'(fault_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
